// File: rtl/ppu_vram_bus_seq.sv
// Sequencer for the PPU multiplexed VRAM bus: ALE address phase, n_RD/n_WR strobe, one-cycle ack.
// Latency: ALE_CYCLES+WAIT_CYCLES+2 cycles from req to ack; req is ignored while busy.
// Optional VBUS_AUTOINC_EN adds an auto-incrementing address pointer (ptr_load/inc32 ports).
module ppu_vram_bus_seq #(
    parameter int DW          = 8,
    parameter int AW          = 14,
    parameter int ALE_CYCLES  = 1,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          PCLK,
    input  logic          n_RES,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
`ifdef VBUS_AUTOINC_EN
    input  logic          ptr_load,
    input  logic          inc32,
`endif
    output logic          ack,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [DW-1:0] ad_out,
    output logic          ad_oe,
    input  logic [DW-1:0] ad_in,
    output logic [AW-DW-1:0] pa_out,
    output logic          ALE,
    output logic          n_RD,
    output logic          n_WR
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_STRB, S_DONE} state_t;

    localparam logic [2:0] ALE_LAST  = 3'(ALE_CYCLES - 1);
    localparam logic [2:0] STRB_LAST = 3'(WAIT_CYCLES);

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [AW-1:0]   req_addr;
    logic            ack_q, ack_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            busy_q, busy_d;
    logic [DW-1:0]   ad_out_q, ad_out_d;
    logic            ad_oe_q, ad_oe_d;
    logic [AW-DW-1:0] pa_out_q, pa_out_d;
    logic            ale_q, ale_d;
    logic            n_rd_q, n_rd_d;
    logic            n_wr_q, n_wr_d;

`ifdef VBUS_AUTOINC_EN
    logic [AW-1:0]   ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_DONE)
            ptr_d = ptr_q + (inc32 ? AW'(32) : AW'(1));
        // A load on the DONE edge overrides the post-transaction increment.
        if (ptr_load)
            ptr_d = addr;
    end

    always_ff @(posedge PCLK or negedge n_RES) begin
        if (!n_RES) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign req_addr = ptr_q;
`else
    assign req_addr = addr;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack_d    = 1'b0;
        rdata_d  = rdata_q;
        ad_out_d = ad_out_q;
        ad_oe_d  = ad_oe_q;
        pa_out_d = pa_out_q;
        ale_d    = ale_q;
        n_rd_d   = n_rd_q;
        n_wr_d   = n_wr_q;

        case (state_q)
            S_IDLE: if (req) begin
                state_d = S_ADDR;
                cnt_d   = '0;
                we_d    = we;
                addr_d  = req_addr;
                wdata_d = wdata;
            end
            S_ADDR: if (cnt_q >= ALE_LAST) begin
                state_d = S_STRB;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
            S_STRB: if (cnt_q >= STRB_LAST) begin
                state_d = S_DONE;
                if (!we_q) rdata_d = ad_in;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // Pad outputs are registered, so they are decoded from the state being entered.
        case (state_d)
            S_ADDR: begin
                ale_d    = 1'b1;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d[DW-1:0];
                pa_out_d = addr_d[AW-1:DW];
                n_rd_d   = 1'b1;
                n_wr_d   = 1'b1;
            end
            S_STRB: begin
                ale_d = 1'b0;
                if (we_d) begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_d;
                    n_wr_d   = 1'b0;
                end else begin
                    ad_oe_d = 1'b0;
                    n_rd_d  = 1'b0;
                end
            end
            S_DONE: begin
                ale_d   = 1'b0;
                ad_oe_d = 1'b0;
                n_rd_d  = 1'b1;
                n_wr_d  = 1'b1;
                ack_d   = 1'b1;
            end
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge PCLK or negedge n_RES) begin
        if (!n_RES) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            ad_out_q <= '0;
            ad_oe_q  <= 1'b0;
            pa_out_q <= '0;
            ale_q    <= 1'b0;
            n_rd_q   <= 1'b1;
            n_wr_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            ad_out_q <= ad_out_d;
            ad_oe_q  <= ad_oe_d;
            pa_out_q <= pa_out_d;
            ale_q    <= ale_d;
            n_rd_q   <= n_rd_d;
            n_wr_q   <= n_wr_d;
        end
    end

    assign ack    = ack_q;
    assign rdata  = rdata_q;
    assign busy   = busy_q;
    assign ad_out = ad_out_q;
    assign ad_oe  = ad_oe_q;
    assign pa_out = pa_out_q;
    assign ALE    = ale_q;
    assign n_RD   = n_rd_q;
    assign n_WR   = n_wr_q;
endmodule

// File: tb/tb_ppu_vram_bus_seq.sv
// Directed bench for ppu_vram_bus_seq: default instance plus a WAIT_CYCLES=0 instance.
module tb_ppu_vram_bus_seq;
    logic        PCLK = 1'b0;
    logic        n_RES;
    logic        req, req0, we, ptr_load, inc32;
    logic [13:0] addr;
    logic [7:0]  wdata, ad_in;

    logic        ack, busy, ad_oe, ALE, n_RD, n_WR;
    logic [7:0]  rdata, ad_out;
    logic [5:0]  pa_out;
    logic        ack0, busy0, ad_oe0, ALE0, n_RD0, n_WR0;
    logic [7:0]  rdata0, ad_out0;
    logic [5:0]  pa_out0;

    int n_chk = 0;
    int n_pass = 0;

    always #5 PCLK = ~PCLK;

    ppu_vram_bus_seq #(.DW(8), .AW(14), .ALE_CYCLES(1), .WAIT_CYCLES(1)) dut (
        .PCLK(PCLK), .n_RES(n_RES), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef VBUS_AUTOINC_EN
        .ptr_load(ptr_load), .inc32(inc32),
`endif
        .ack(ack), .rdata(rdata), .busy(busy), .ad_out(ad_out), .ad_oe(ad_oe),
        .ad_in(ad_in), .pa_out(pa_out), .ALE(ALE), .n_RD(n_RD), .n_WR(n_WR)
    );

    ppu_vram_bus_seq #(.DW(8), .AW(14), .ALE_CYCLES(1), .WAIT_CYCLES(0)) dut0 (
        .PCLK(PCLK), .n_RES(n_RES), .req(req0), .we(we), .addr(addr), .wdata(wdata),
`ifdef VBUS_AUTOINC_EN
        .ptr_load(ptr_load), .inc32(inc32),
`endif
        .ack(ack0), .rdata(rdata0), .busy(busy0), .ad_out(ad_out0), .ad_oe(ad_oe0),
        .ad_in(ad_in), .pa_out(pa_out0), .ALE(ALE0), .n_RD(n_RD0), .n_WR(n_WR0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One transaction on the default instance; reports phase lengths, ack position and bus address.
    task automatic txn(input bit wr, input logic [13:0] a, input logic [7:0] wd,
                       input bit load_at_done, input logic [13:0] load_val,
                       output int ale_n, output int strb_n, output int ack_i,
                       output logic [13:0] seen_a, output bit pads_ok);
        req = 1'b1; we = wr; addr = a; wdata = wd;
        ale_n = 0; strb_n = 0; ack_i = 0; seen_a = '0; pads_ok = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge PCLK);
            if (ALE) begin
                ale_n++;
                seen_a = {pa_out, ad_out};
                if (!ad_oe) pads_ok = 1'b0;
            end
            if (!n_RD || !n_WR) begin
                strb_n++;
                if (wr && !(ad_oe && ad_out == wd && n_RD)) pads_ok = 1'b0;
                if (!wr && (ad_oe || !n_WR)) pads_ok = 1'b0;
            end
            if (ack) begin
                ack_i = i;
                req = 1'b0;
                if (load_at_done) begin
                    ptr_load = 1'b1;
                    addr = load_val;
                end
                break;
            end
        end
        req = 1'b0;
        if (load_at_done) begin
            @(negedge PCLK);
            ptr_load = 1'b0;
        end
    endtask

    int ale_n, strb_n, ack_i, acks, idle_n;
    logic [13:0] seen_a;
    bit pads_ok;

    initial begin
        n_RES = 1'b0; req = 1'b0; req0 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        ad_in = 8'hA5; ptr_load = 1'b0; inc32 = 1'b0;
        #12;
        check("rst_ale", ALE, 0);
        check("rst_nrd_nwr", {n_RD, n_WR}, 2'b11);
        check("rst_oe_ack_busy", {ad_oe, ack, busy}, 3'b000);
        check("rst_ad_pa_rdata", {ad_out, pa_out, rdata}, 0);
        @(negedge PCLK); n_RES = 1'b1;
        @(negedge PCLK);

        // Default read: ALE 1 cycle, n_RD 2 cycles, ack in cycle 4.
        txn(1'b0, 14'h2345, 8'h00, 1'b0, 14'h0, ale_n, strb_n, ack_i, seen_a, pads_ok);
        check("rd_ale_cycles", ale_n, 1);
        check("rd_strb_cycles", strb_n, 2);
        check("rd_ack_at", ack_i, 4);
        check("rd_addr", seen_a, 14'h2345);
        check("rd_pads", pads_ok, 1);
        check("rd_rdata", rdata, 8'hA5);
        @(negedge PCLK);
        check("rd_idle_ack_low", {ack, busy}, 2'b00);
        check("rd_pa_persist", pa_out, 6'h23);

        // Write on the WAIT_CYCLES=0 instance.
        req0 = 1'b1; we = 1'b1; addr = 14'h3F10; wdata = 8'h3C;
        strb_n = 0; ack_i = 0; pads_ok = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge PCLK);
            if (!n_WR0) begin
                strb_n++;
                if (!(ad_oe0 && ad_out0 == 8'h3C && n_RD0 && !ALE0)) pads_ok = 1'b0;
            end
            if (ack0) begin ack_i = i; req0 = 1'b0; break; end
        end
        req0 = 1'b0;
        check("wr_strb_cycles", strb_n, 1);
        check("wr_pads", pads_ok, 1);
        check("wr_ack_at", ack_i, 3);
        check("wr_pa", pa_out0, 6'h3F);

        // req held high: back-to-back transactions with a single IDLE cycle between.
        @(negedge PCLK);
        ad_in = 8'h5A; we = 1'b0; addr = 14'h0177; req = 1'b1;
        acks = 0; idle_n = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge PCLK);
            if (ack) acks++;
            if (!busy) idle_n++;
        end
        req = 1'b0;
        check("b2b_acks", acks, 2);
        check("b2b_idle_cycles", idle_n, 1);
        check("b2b_rdata", rdata, 8'h5A);
        for (int i = 0; i < 4; i++) @(negedge PCLK);
        check("b2b_no_third", busy, 0);

        // req pulsed during STRB is ignored.
        req = 1'b1; addr = 14'h0011;
        @(negedge PCLK); req = 1'b0;
        @(negedge PCLK); req = 1'b1;
        @(negedge PCLK); req = 1'b0;
        acks = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ack) acks++;
            @(negedge PCLK);
        end
        check("pulse_one_ack", acks, 1);

        // Asynchronous reset in the middle of a read strobe.
        req = 1'b1; addr = 14'h0222;
        @(negedge PCLK); req = 1'b0;
        @(negedge PCLK);
        check("mid_strb_nrd", n_RD, 0);
        #2 n_RES = 1'b0;
        #1;
        check("async_rst_nrd_oe", {n_RD, ad_oe}, 2'b10);
        check("async_rst_busy_ack", {busy, ack}, 2'b00);
        @(negedge PCLK); n_RES = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge PCLK);
            if (ack || busy) acks++;
        end
        check("rst_no_ack", acks, 0);

`ifdef VBUS_AUTOINC_EN
        ptr_load = 1'b1; addr = 14'h3FFF; inc32 = 1'b0;
        @(negedge PCLK); ptr_load = 1'b0;
        txn(1'b0, 14'h0ABC, 8'h00, 1'b0, 14'h0, ale_n, strb_n, ack_i, seen_a, pads_ok);
        check("ptr_loaded_addr", seen_a, 14'h3FFF);
        inc32 = 1'b1;
        txn(1'b0, 14'h0ABC, 8'h00, 1'b0, 14'h0, ale_n, strb_n, ack_i, seen_a, pads_ok);
        check("ptr_wrap_addr", seen_a, 14'h0000);
        txn(1'b0, 14'h0ABC, 8'h00, 1'b0, 14'h0, ale_n, strb_n, ack_i, seen_a, pads_ok);
        check("ptr_inc32_addr", seen_a, 14'h0020);
        txn(1'b0, 14'h0ABC, 8'h00, 1'b1, 14'h1234, ale_n, strb_n, ack_i, seen_a, pads_ok);
        check("ptr_pre_load_addr", seen_a, 14'h0040);
        txn(1'b0, 14'h0ABC, 8'h00, 1'b0, 14'h0, ale_n, strb_n, ack_i, seen_a, pads_ok);
        check("ptr_load_wins", seen_a, 14'h1234);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
